// File: rtl/me_search_ram.sv
// me_search_ram: banked current-block and search-window store feeding the me core.
// Loads a raster pixel stream, then serves rotated, address-translated one-cycle reads.
module me_search_ram #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_start,
    input  logic                       pix_valid,
    input  logic [7:0]                 pix_data,
    output logic                       pix_ready,
    output logic                       busy,
    output logic                       me_start,
    input  logic                       en_ram,
    input  logic [5:0]                 addr,
    input  logic [5:0]                 amt,
    output logic [0:MACRO_DIM][7:0]    pixel_spr_out,
    output logic [0:MACRO_DIM-1][7:0]  pixel_cpr_out
);
    localparam int PORT_WIDTH = MACRO_DIM + 1;
    localparam int S_DEPTH    = SEARCH_DIM * (SEARCH_DIM / MACRO_DIM);
    localparam int BW         = $clog2(PORT_WIDTH);
    localparam int AW         = $clog2(S_DEPTH);
    localparam int CW         = $clog2(MACRO_DIM);

    typedef enum logic [2:0] {IDLE, LOAD_CUR, LOAD_SRCH, DONE, SERVE} state_t;

    state_t state_q, state_d;
    logic [5:0] col_q, col_d, row_q, row_d;
    logic [0:MACRO_DIM][7:0] spr_q, spr_rd;
    logic [0:MACRO_DIM-1][7:0] cpr_q, cpr_rd;
    logic [7:0] cur_mem [MACRO_DIM][MACRO_DIM];
    logic [7:0] srch_mem [PORT_WIDTH][S_DEPTH];
    logic beat, rd, col_end, row_end;
    logic [5:0] last;
    logic [BW-1:0] s_bank;
    logic [AW-1:0] s_addr;

    assign pix_ready     = state_q == LOAD_CUR || state_q == LOAD_SRCH;
    assign busy          = pix_ready || state_q == DONE;
    assign me_start      = state_q == DONE;
    assign beat          = pix_valid & pix_ready;
    assign rd            = state_q == SERVE && en_ram;
    assign last          = (state_q == LOAD_CUR) ? 6'(MACRO_DIM - 1) : 6'(SEARCH_DIM - 1);
    assign col_end       = col_q == last;
    assign row_end       = row_q == last;
    assign pixel_spr_out = spr_q;
    assign pixel_cpr_out = cpr_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        case (state_q)
            IDLE, SERVE: if (load_start) begin
                state_d = LOAD_CUR;
                col_d   = '0;
                row_d   = '0;
            end
            LOAD_CUR, LOAD_SRCH: if (beat) begin
                col_d = col_end ? '0 : col_q + 6'd1;
                row_d = col_end ? (row_end ? '0 : row_q + 6'd1) : row_q;
                if (col_end && row_end) state_d = (state_q == LOAD_CUR) ? LOAD_SRCH : DONE;
            end
            DONE:    state_d = SERVE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            spr_q   <= '0;
            cpr_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            if (rd) begin
                spr_q <= spr_rd;
                cpr_q <= cpr_rd;
            end
        end
    end

    // Search column c lives in bank c mod PORT_WIDTH, one SEARCH_DIM-row segment per wrap.
    assign s_bank = BW'(col_q % 6'(PORT_WIDTH));
    assign s_addr = AW'(col_q / 6'(PORT_WIDTH)) * AW'(SEARCH_DIM) + AW'(row_q);

    always_ff @(posedge clk) begin
        if (beat && state_q == LOAD_CUR) cur_mem[col_q[CW-1:0]][row_q[CW-1:0]] <= pix_data;
        if (beat && state_q == LOAD_SRCH) srch_mem[s_bank][s_addr] <= pix_data;
    end

    for (genvar l = 0; l < PORT_WIDTH; l++) begin : g_spr
        logic [6:0]    sum;
        logic [BW-1:0] bank;
        logic [AW-1:0] taddr;
        assign sum   = 7'(l) + 7'(amt);
        assign bank  = BW'(sum >= 7'(PORT_WIDTH) ? sum - 7'(PORT_WIDTH) : sum);
        // Banks left of the rotation point already hold the next column segment.
        assign taddr = AW'(addr) + ((6'(bank) < amt) ? AW'(SEARCH_DIM) : AW'(0));
        assign spr_rd[l] = (amt <= 6'(MACRO_DIM) && taddr < AW'(S_DEPTH)) ? srch_mem[bank][taddr] : 8'd0;
    end

    for (genvar l = 0; l < MACRO_DIM; l++) begin : g_cpr
        assign cpr_rd[l] = (addr < 6'(MACRO_DIM)) ? cur_mem[l][addr[CW-1:0]] : 8'd0;
    end
endmodule

// File: tb/tb_me_search_ram.sv
// tb_me_search_ram: scoreboard bench for the me_search_ram load FSM and banked read port.
module tb_me_search_ram;
    logic clk = 1'b0;
    logic rst, load_start, pix_valid, pix_ready, busy, me_start, en_ram;
    logic [7:0] pix_data;
    logic [5:0] addr, amt;
    logic [0:16][7:0] pixel_spr_out;
    logic [0:15][7:0] pixel_cpr_out;

    typedef struct packed {
        logic [5:0]       a;
        logic [5:0]       m;
        logic [0:16]      sv;
        logic [0:16][7:0] spr;
        logic [0:15][7:0] cpr;
    } exp_t;

    int checks = 0, failures = 0, starts = 0;
    logic [7:0] cur_img [16][16];
    logic [7:0] srch_img [48][48];
    exp_t sb [$];
    exp_t last_exp;

    me_search_ram dut (
        .clk(clk), .rst(rst), .load_start(load_start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .busy(busy), .me_start(me_start),
        .en_ram(en_ram), .addr(addr), .amt(amt),
        .pixel_spr_out(pixel_spr_out), .pixel_cpr_out(pixel_cpr_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (me_start === 1'b1) starts++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e = '0;
        e.sv = '1;
        return e;
    endfunction

    // Expected slice: columns amt + 17*(addr/48) + lane of row addr%48.
    function automatic exp_t model(input logic [5:0] a, input logic [5:0] m);
        exp_t e = zero_exp();
        int col;
        e.a = a;
        e.m = m;
        for (int l = 0; l < 17; l++) begin
            col = int'(m) + 17 * (int'(a) / 48) + l;
            if (m <= 16) begin
                e.sv[l] = col < 48;
                if (col < 48) e.spr[l] = srch_img[int'(a) % 48][col];
            end
        end
        for (int l = 0; l < 16; l++) e.cpr[l] = (a < 16) ? cur_img[a][l] : 8'd0;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        for (int l = 0; l < 17; l++)
            if (e.sv[l]) check($sformatf("spr a=%0d amt=%0d lane%0d", e.a, e.m, l), 32'(pixel_spr_out[l]), 32'(e.spr[l]));
        for (int l = 0; l < 16; l++)
            check($sformatf("cpr a=%0d lane%0d", e.a, l), 32'(pixel_cpr_out[l]), 32'(e.cpr[l]));
    endtask

    task automatic rd(input bit en, input logic [5:0] a, input logic [5:0] m);
        if (sb.size() > 0) compare(sb.pop_front());
        en_ram = en;
        addr = a;
        amt = m;
        if (en) last_exp = model(a, m);
        sb.push_back(last_exp);
        @(negedge clk);
    endtask

    task automatic flush();
        en_ram = 1'b0;
        while (sb.size() > 0) compare(sb.pop_front());
    endtask

    task automatic check_zero(input string tag);
        check({tag, " spr"}, 32'(|pixel_spr_out), 0);
        check({tag, " cpr"}, 32'(|pixel_cpr_out), 0);
        check({tag, " ready"}, 32'(pix_ready), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " me_start"}, 32'(me_start), 0);
    endtask

    task automatic load(input int seed, input bit stall, input bit poke, input int abort_at);
        int k = 0, cyc = 0, j;
        bit v;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        check("load ready", 32'(pix_ready), 1);
        check("load busy", 32'(busy), 1);
        while (k < 2560 && cyc < 20000) begin
            v = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_valid = v;
            j = (k < 256) ? k : k - 256;
            pix_data = 8'(j + seed);
            load_start = poke && k == 1500;
            if (k == abort_at) begin
                #2 rst = 1'b1;
                #1 check_zero("async reset");
                #1 rst = 1'b0;
                pix_valid = 1'b0;
                load_start = 1'b0;
                @(negedge clk);
                check("abort idle ready", 32'(pix_ready), 0);
                check("abort idle busy", 32'(busy), 0);
                last_exp = zero_exp();
                return;
            end
            if (v && pix_ready) begin
                if (k < 256) cur_img[k / 16][k % 16] = pix_data;
                else srch_img[j / 48][j % 48] = pix_data;
                k++;
            end
            cyc++;
            @(negedge clk);
        end
        pix_valid = 1'b0;
        load_start = 1'b0;
        check("load beats", 32'(k), 2560);
        check("done me_start", 32'(me_start), 1);
        check("done busy", 32'(busy), 1);
        check("done ready", 32'(pix_ready), 0);
        @(negedge clk);
        check("serve me_start", 32'(me_start), 0);
        check("serve busy", 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        pix_valid = 1'b0;
        pix_data = '0;
        en_ram = 1'b0;
        addr = '0;
        amt = '0;
        last_exp = zero_exp();
        repeat (2) @(negedge clk);
        check_zero("in reset");
        rst = 1'b0;
        @(negedge clk);
        check_zero("after reset");

        load(0, 1'b0, 1'b0, -1);
        check("unrotated spr lane16", 32'(model(6'd5, 6'd0).spr[16]), 0);
        rd(1, 5, 0);
        rd(1, 5, 3);
        rd(1, 50, 16);
        rd(0, 9, 9);
        rd(1, 0, 0);
        rd(1, 15, 1);
        rd(1, 47, 16);
        rd(1, 63, 5);
        rd(1, 20, 0);
        flush();

        #2 rst = 1'b1;
        #1 check_zero("mid reset");
        #1 rst = 1'b0;
        last_exp = zero_exp();
        @(negedge clk);

        load(3, 1'b1, 1'b1, -1);
        rd(1, 5, 0);
        rd(1, 5, 3);
        rd(1, 50, 16);
        rd(1, 33, 7);
        flush();

        load(9, 1'b0, 1'b0, 1000);
        load(0, 1'b0, 1'b0, -1);
        rd(1, 5, 0);
        rd(1, 5, 17);
        rd(0, 1, 2);
        rd(1, 63, 63);
        rd(1, 5, 16);
        flush();

        repeat (2) @(negedge clk);
        check("me_start count", 32'(starts), 3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
